int8_requant_stream: RTL and testbench

//  Streaming per-channel requantiser downstream of the INT8 MAC/dot-product stage.

---
 rtl/nn_dtypes_pkg.sv | 35 +++
 rtl/requant_cfg_table.sv | 29 ++
 rtl/int8_requant_stream.sv | 121 ++++++++++++
 tb/tb_int8_requant_stream.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_dtypes_pkg.sv
// Shared INT8 datapath types, requantiser config record and rounding/clamping helpers.
package nn_dtypes_pkg;

  typedef logic signed [7:0] int8_t;

  typedef struct packed {
    logic [15:0] scale;
    logic [4:0]  shift;
    int8_t       zp;
  } requant_cfg_t;

  localparam logic [15:0] REQ_SCALE_ONE = 16'hFFFF;
  localparam requant_cfg_t REQ_CFG_RESET = '{scale: REQ_SCALE_ONE, shift: 5'd0, zp: 8'sd0};

  // Round half toward +inf, then arithmetic shift by 16+shift; result always fits 34 bits.
  function automatic logic signed [33:0] round_shift(input logic signed [48:0] prod,
                                                     input logic [4:0]         shift);
    logic signed [49:0] sum;
    logic signed [49:0] q;
    sum = 50'(prod) + (50'sd1 <<< (6'(shift) + 6'd15));
    q   = sum >>> (6'(shift) + 6'd16);
    return q[33:0];
  endfunction

  function automatic logic is_sat_int8(input logic signed [34:0] v);
    return (v > 35'sd127) || (v < -35'sd128);
  endfunction

  function automatic int8_t clamp_int8(input logic signed [34:0] v, input int8_t lo);
    if (v > 35'sd127) return 8'sd127;
    if (v < 35'(lo)) return lo;
    return v[7:0];
  endfunction

endpackage

// File: rtl/requant_cfg_table.sv
// Per-channel requantiser config register file: one synchronous write port, one async read port.
module requant_cfg_table
  import nn_dtypes_pkg::*;
#(
  parameter int unsigned NUM_CH = 16,
  localparam int unsigned CW = $clog2(NUM_CH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [CW-1:0] waddr,
  input  requant_cfg_t wdata,
  input  logic [CW-1:0] raddr,
  output requant_cfg_t rdata
);

  requant_cfg_t table_q [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) table_q[i] <= REQ_CFG_RESET;
    end else if (we) begin
      table_q[waddr] <= wdata;
    end
  end

  assign rdata = table_q[raddr];

endmodule

// File: rtl/int8_requant_stream.sv
// Streaming per-channel INT32 -> INT8 requantiser: scale, rounding shift, zero point,
// optional quantised ReLU and saturation, 3-stage pipeline with global stall on backpressure.
module int8_requant_stream
  import nn_dtypes_pkg::*;
#(
  parameter int unsigned NUM_CH   = 16,
  parameter int unsigned SATCNT_W = 16,
  localparam int unsigned CW = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [31:0]  in_acc,
  input  logic                in_last,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_addr,
  input  logic [15:0]         cfg_scale,
  input  logic [4:0]          cfg_shift,
  input  logic [7:0]          cfg_zp,
  input  logic                relu_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [7:0]   out_data,
  output logic [CW-1:0]       out_ch,
  output logic                out_sat,
  output logic [SATCNT_W-1:0] sat_count
);

  logic         stall, accept;
  logic [CW-1:0] ch_cnt, ch_next;
  requant_cfg_t cfg_rd;

  logic               s1_valid;
  logic signed [31:0] s1_acc;
  logic [CW-1:0]      s1_ch;
  requant_cfg_t       s1_cfg;

  logic               s2_valid;
  logic signed [48:0] s2_prod;
  logic [CW-1:0]      s2_ch;
  logic [4:0]         s2_shift;
  int8_t              s2_zp;

  logic signed [48:0] prod;
  logic signed [33:0] rnd;
  logic signed [34:0] v;
  int8_t              lo;

  requant_cfg_table #(.NUM_CH(NUM_CH)) u_cfg (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata ('{scale: cfg_scale, shift: cfg_shift, zp: cfg_zp}),
    .raddr (ch_cnt),
    .rdata (cfg_rd)
  );

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign ch_next  = (in_last || ch_cnt == CW'(NUM_CH - 1)) ? '0 : ch_cnt + 1'b1;

  always_comb begin
    prod = 49'(s1_acc) * 49'($signed({1'b0, s1_cfg.scale}));
    rnd  = round_shift(s2_prod, s2_shift);
    v    = 35'(rnd) + 35'(s2_zp);
    lo   = relu_en ? s2_zp : -8'sd128;
  end

  // Every stage shares the single stall enable, so beats never overtake or get dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt    <= '0;
      s1_valid  <= 1'b0;
      s1_acc    <= '0;
      s1_ch     <= '0;
      s1_cfg    <= REQ_CFG_RESET;
      s2_valid  <= 1'b0;
      s2_prod   <= '0;
      s2_ch     <= '0;
      s2_shift  <= '0;
      s2_zp     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_acc <= in_acc;
        s1_ch  <= ch_cnt;
        s1_cfg <= cfg_rd;
        ch_cnt <= ch_next;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod  <= prod;
        s2_ch    <= s1_ch;
        s2_shift <= s1_cfg.shift;
        s2_zp    <= s1_cfg.zp;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= clamp_int8(v, lo);
        out_ch   <= s2_ch;
        out_sat  <= is_sat_int8(v);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && sat_count != '1) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_int8_requant_stream.sv
// Bench for int8_requant_stream: directed cases plus randomized streaming against a behavioural model.
module tb_int8_requant_stream;

  localparam int NUM_CH = 16;
  localparam int CW     = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_acc;
  logic               in_last;
  logic               cfg_we;
  logic [CW-1:0]      cfg_addr;
  logic [15:0]        cfg_scale;
  logic [4:0]         cfg_shift;
  logic [7:0]         cfg_zp;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic [CW-1:0]      out_ch;
  logic               out_sat;
  logic [15:0]        sat_count;

  int8_requant_stream #(.NUM_CH(NUM_CH), .SATCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .in_last(in_last), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .relu_en(relu_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int data; int ch; bit sat; } exp_t;
  exp_t q[$];
  int m_scale [NUM_CH];
  int m_shift [NUM_CH];
  int m_zp    [NUM_CH];
  int m_ch;
  int m_sat;

  function automatic void model(input int acc, input int scale, input int shift, input int zp,
                                input bit relu, output int data, output bit sat);
    longint prod, r, v, lo;
    prod = longint'(acc) * longint'(scale);
    r    = (prod + (longint'(1) << (15 + shift))) >>> (16 + shift);
    v    = r + zp;
    lo   = relu ? zp : -128;
    sat  = (v > 127) || (v < -128);
    if (v > 127) data = 127;
    else if (v < lo) data = int'(lo);
    else data = int'(v);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      m_scale[i] = 65535; m_shift[i] = 0; m_zp[i] = 0;
    end
    m_ch = 0;
    m_sat = 0;
  endtask

  // ---------------- compare process ----------------
  bit stall_prev = 0;
  int h_data, h_ch;
  bit h_sat;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("in_ready", in_ready, !(out_valid && !out_ready));
      check("sat_count", sat_count, m_sat);
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, h_data);
        check("hold_ch", out_ch, h_ch);
        check("hold_sat", out_sat, h_sat);
      end
      stall_prev = out_valid && !out_ready;
      h_data = out_data; h_ch = out_ch; h_sat = out_sat;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e.data);
          check("out_ch", out_ch, e.ch);
          check("out_sat", out_sat, e.sat);
          if (e.sat && m_sat != 65535) m_sat++;
        end
      end
      if (in_valid && in_ready) begin
        model(int'(in_acc), m_scale[m_ch], m_shift[m_ch], int'($signed(cfg_zp_of(m_ch))),
              relu_en, e.data, e.sat);
        e.ch = m_ch;
        q.push_back(e);
        m_ch = (in_last || m_ch == NUM_CH - 1) ? 0 : m_ch + 1;
      end
      if (cfg_we) begin
        m_scale[cfg_addr] = int'(cfg_scale);
        m_shift[cfg_addr] = int'(cfg_shift);
        m_zp[cfg_addr]    = int'($signed(cfg_zp));
      end
    end else begin
      stall_prev = 0;
    end
  end

  function automatic logic [7:0] cfg_zp_of(input int ch);
    return 8'(m_zp[ch]);
  endfunction

  // ---------------- driver helpers ----------------
  task automatic write_cfg(input int ch, input int scale, input int shift, input int zp);
    cfg_we = 1; cfg_addr = CW'(ch); cfg_scale = 16'(scale); cfg_shift = 5'(shift); cfg_zp = 8'(zp);
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic send(input int acc, input bit last);
    bit ok;
    int b;
    in_valid = 1; in_acc = acc; in_last = last;
    b = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      b++;
    end while (!ok && b < 100);
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int b;
    in_valid = 0; in_last = 0; out_ready = 1; cfg_we = 0;
    b = 0;
    while ((q.size() != 0 || out_valid) && b < 50) begin
      @(posedge clk); #1; b++;
    end
    @(posedge clk); #1;
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_count", sat_count, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d, n;
    bit s;
    rst_n = 1; in_valid = 0; in_acc = 0; in_last = 0; cfg_we = 0; cfg_addr = 0;
    cfg_scale = 0; cfg_shift = 0; cfg_zp = 0; relu_en = 0; out_ready = 1;
    model_reset();
    #2;
    do_reset();
    check("rst_in_ready", in_ready, 1);

    // model pinned against hand-computed values
    model(200, 32768, 0, -5, 0, d, s);     check("pin_basic", d, 95);
    model(3, 32768, 0, 0, 0, d, s);        check("pin_rnd_p3", d, 2);
    model(-3, 32768, 0, 0, 0, d, s);       check("pin_rnd_m3", d, -1);
    model(1, 32768, 0, 0, 0, d, s);        check("pin_rnd_p1", d, 1);
    model(-1, 32768, 0, 0, 0, d, s);       check("pin_rnd_m1", d, 0);
    model(100000, 32768, 0, 0, 0, d, s);   check("pin_sat_hi", d, 127); check("pin_sat_hi_f", s, 1);
    model(-100000, 32768, 0, 0, 0, d, s);  check("pin_sat_lo", d, -128); check("pin_sat_lo_f", s, 1);
    model(-50, 32768, 0, 10, 1, d, s);     check("pin_relu_lo", d, 10); check("pin_relu_f", s, 0);
    model(40, 32768, 0, 10, 1, d, s);      check("pin_relu_hi", d, 30);

    // basic result and 3-cycle latency
    write_cfg(0, 16'h8000, 0, -5);
    in_valid = 1; in_acc = 200; in_last = 1;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    n = 1;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    check("latency", n, 3);
    check("basic_data", out_data, 95);
    check("basic_ch", out_ch, 0);
    check("basic_sat", out_sat, 0);
    drain();

    // rounding
    write_cfg(0, 16'h8000, 0, 0);
    send(3, 1); send(-3, 1); send(1, 1); send(-1, 1);
    drain();

    // saturation
    send(100000, 1); send(-100000, 1);
    drain();
    check("sat_count_2", sat_count, 2);

    // quantised ReLU
    relu_en = 1;
    write_cfg(0, 16'h8000, 0, 10);
    send(-50, 1); send(40, 1);
    drain();
    relu_en = 0;

    // channel wrap: 20 beats, last on the 20th, then one more
    for (int i = 0; i < NUM_CH; i++)
      write_cfg(i, $urandom_range(0, 65535), $urandom_range(0, 8), $urandom_range(0, 255));
    for (int i = 0; i < 20; i++) send($urandom_range(0, 2000000) - 1000000, i == 19);
    send(12345, 0);
    in_valid = 0;
    check("wrap_next_ch", m_ch, 1);
    drain();

    // backpressure mid-stream
    fork
      for (int i = 0; i < 8; i++) send($urandom_range(0, 200000) - 100000, 0);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        #1 check("stall_in_ready", in_ready, 0);
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();

    // reset mid-stream drops everything in flight
    in_valid = 1; in_acc = 777; in_last = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1;
    model_reset();
    in_valid = 0;
    check("midrst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    repeat (6) @(posedge clk);
    #1 check("midrst_quiet", out_valid, 0);

    // randomized streaming, without and with ReLU
    for (int pass = 0; pass < 2; pass++) begin
      relu_en = pass[0];
      for (int c = 0; c < 600; c++) begin
        int cls;
        in_valid  = $urandom_range(0, 3) != 0;
        cls = $urandom_range(0, 2);
        in_acc = (cls == 0) ? $urandom_range(0, 400) - 200 :
                 (cls == 1) ? $urandom_range(0, 400000) - 200000 : $urandom;
        in_last   = $urandom_range(0, 7) == 0;
        out_ready = $urandom_range(0, 3) != 0;
        cfg_we    = $urandom_range(0, 9) == 0;
        cfg_addr  = CW'($urandom_range(0, NUM_CH - 1));
        cfg_scale = 16'($urandom);
        cfg_shift = 5'($urandom_range(0, 12));
        cfg_zp    = 8'($urandom);
        @(posedge clk); #1;
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
